// File: rtl/popcount_pkg.sv
// Shared constants, widths and types for the shared popcount scheduler.
// The SWAR masks assume a 32-bit word.
package popcount_pkg;

    localparam logic [31:0] M1  = 32'h5555_5555;
    localparam logic [31:0] M2  = 32'h3333_3333;
    localparam logic [31:0] M4  = 32'h0707_0707;
    localparam logic [31:0] M8  = 32'h001F_001F;
    localparam logic [31:0] M16 = 32'h0000_003F;

    // One extra bit so that an all-ones word still fits in the count.
    function automatic int count_w(input int data_w);
        return $clog2(data_w) + 1;
    endfunction

    localparam int CNT_W_MAX = count_w(32);
    localparam int ID_W_MAX  = 3;

    typedef logic [CNT_W_MAX-1:0] count_t;
    typedef logic [ID_W_MAX-1:0]  id_t;

endpackage

// File: rtl/popcount_rr_scheduler_if.sv
// Request/response bus between the requesters, the consumer and the shared ones-counter.
// The master side drives requests and response acceptance; the slave side is the scheduler.
interface popcount_rr_scheduler_if
    import popcount_pkg::*;
#(
    parameter int NREQ   = 4,
    parameter int DATA_W = 32,
    parameter int CNT_W  = count_w(DATA_W),
    parameter int ID_W   = (NREQ > 2) ? $clog2(NREQ) : 1
);

    logic [NREQ-1:0]        req_valid;
    logic [NREQ*DATA_W-1:0] req_data;
    logic [NREQ-1:0]        req_ready;
    logic                   rsp_valid;
    logic                   rsp_ready;
    logic [ID_W-1:0]        rsp_id;
    logic [CNT_W-1:0]       rsp_count;

    modport master (
        output req_valid,
        output req_data,
        output rsp_ready,
        input  req_ready,
        input  rsp_valid,
        input  rsp_id,
        input  rsp_count
    );

    modport slave (
        input  req_valid,
        input  req_data,
        input  rsp_ready,
        output req_ready,
        output rsp_valid,
        output rsp_id,
        output rsp_count
    );

endinterface

// File: rtl/popcount_pipe.sv
// Two-stage SWAR ones-counter with an output register, advanced by a single global enable.
// Stage valid flags and the output register are reset; in-stage data is not.
module popcount_pipe
    import popcount_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int CNT_W  = count_w(DATA_W),
    parameter int ID_W   = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic              in_valid,
    input  logic [ID_W-1:0]   in_id,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    output logic [ID_W-1:0]   out_id,
    output logic [CNT_W-1:0]  out_count,
    output logic              occupied
);

    logic [DATA_W-1:0] t1, t2, t3, t4;
    logic [CNT_W-1:0]  cnt_d;

    logic              vld_p0, vld_p1, vld_p2;
    logic [ID_W-1:0]   id_p0, id_p1, id_p2;
    logic [DATA_W-1:0] sum_p0, sum_p1;
    logic [CNT_W-1:0]  cnt_p2;

    // S1 input: 2-bit pair sums, then 4-bit nibble sums
    always_comb begin
        t1 = in_data - ((in_data >> 1) & M1);
        t2 = (t1 & M2) + ((t1 >> 2) & M2);
    end

    // S2 input: byte sums; a nibble sum is at most 4, so three bits per nibble suffice
    always_comb begin
        t3 = (sum_p0 & M4) + ((sum_p0 >> 4) & M4);
    end

    // Output register input: 16-bit fold, then 32-bit fold
    always_comb begin
        t4    = (sum_p1 & M8) + ((sum_p1 >> 8) & M8);
        cnt_d = CNT_W'((t4 & M16) + ((t4 >> 16) & M16));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            vld_p0 <= 1'b0;
            vld_p1 <= 1'b0;
            vld_p2 <= 1'b0;
            id_p2  <= '0;
            cnt_p2 <= '0;
        end else if (en) begin
            vld_p0 <= in_valid;
            vld_p1 <= vld_p0;
            vld_p2 <= vld_p1;
            id_p2  <= id_p1;
            cnt_p2 <= cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        if (en) begin
            id_p0  <= in_id;
            sum_p0 <= t2;
            id_p1  <= id_p0;
            sum_p1 <= t3;
        end
    end

    assign out_valid = vld_p2;
    assign out_id    = id_p2;
    assign out_count = cnt_p2;
    assign occupied  = vld_p0 | vld_p1 | vld_p2;

endmodule

// File: rtl/popcount_rr_scheduler.sv
// Round-robin arbiter sharing one pipelined 32-bit ones-counter among NREQ requesters.
// Results return in acceptance order on one response bus, tagged with the requester id.
module popcount_rr_scheduler
    import popcount_pkg::*;
#(
    parameter int NREQ   = 4,
    parameter int DATA_W = 32,
    parameter int CNT_W  = count_w(DATA_W),
    parameter int ID_W   = (NREQ > 2) ? $clog2(NREQ) : 1
) (
    input  logic                   clk,
    input  logic                   rst,
    popcount_rr_scheduler_if.slave bus,
    output logic                   busy
);

    generate
        if (DATA_W != 32) begin : g_bad_data_w
            $error("popcount_rr_scheduler: DATA_W must be 32");
        end
        if (NREQ < 2 || NREQ > 8) begin : g_bad_nreq
            $error("popcount_rr_scheduler: NREQ must be in 2..8");
        end
    endgenerate

    logic [ID_W-1:0]   ptr_q;
    logic [ID_W-1:0]   grant_id;
    logic              grant_found;
    logic              stall;
    logic              advance;
    logic              handshake;
    logic [DATA_W-1:0] grant_data;

    // Scanning downward lets the candidate closest to the pointer overwrite the others.
    function automatic logic [ID_W:0] rr_pick(input logic [NREQ-1:0] valid,
                                              input logic [ID_W-1:0] ptr);
        logic [ID_W:0] res;
        logic [ID_W:0] idx;
        res = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            idx = {1'b0, ptr} + (ID_W + 1)'(k);
            if (idx >= (ID_W + 1)'(NREQ)) begin
                idx = idx - (ID_W + 1)'(NREQ);
            end
            if (valid[idx[ID_W-1:0]]) begin
                res = {1'b1, idx[ID_W-1:0]};
            end
        end
        return res;
    endfunction

    always_comb begin
        {grant_found, grant_id} = rr_pick(bus.req_valid, ptr_q);
    end

    // A stalled output freezes every stage, so nothing may be accepted either.
    assign stall         = bus.rsp_valid & ~bus.rsp_ready;
    assign advance       = ~stall;
    assign handshake     = grant_found & advance;
    assign bus.req_ready = handshake ? (NREQ'(1) << grant_id) : '0;
    assign grant_data    = bus.req_data[grant_id*DATA_W +: DATA_W];

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q <= '0;
        end else if (handshake) begin
            ptr_q <= (grant_id == ID_W'(NREQ - 1)) ? '0 : grant_id + 1'b1;
        end
    end

    popcount_pipe #(
        .DATA_W (DATA_W),
        .CNT_W  (CNT_W),
        .ID_W   (ID_W)
    ) u_pipe (
        .clk       (clk),
        .rst       (rst),
        .en        (advance),
        .in_valid  (handshake),
        .in_id     (grant_id),
        .in_data   (grant_data),
        .out_valid (bus.rsp_valid),
        .out_id    (bus.rsp_id),
        .out_count (bus.rsp_count),
        .occupied  (busy)
    );

endmodule
